// File: rtl/sort8_pkg.sv
// sort8_pkg: shared types and defaults for the streaming insertion sorter.
//   state_t   : sorter FSM states (LOAD, DRAIN)
//   slot_op_t : per-slot next-value select
//   slot_t    : canonical slot layout (value, plus arrival index when
//               SORT8_IDX_EN is defined)
// Optional feature macro: SORT8_IDX_EN (arrival-index tracking).
package sort8_pkg;

    localparam int unsigned SORT8_W  = 8;
    localparam int unsigned SORT8_N  = 8;
    localparam int unsigned SORT8_IW = $clog2(SORT8_N);

    typedef enum logic {
        LOAD,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_NEW,
        OP_UP,
        OP_DOWN
    } slot_op_t;

    typedef struct packed {
        logic [SORT8_W-1:0]  value;
`ifdef SORT8_IDX_EN
        logic [SORT8_IW-1:0] idx;
`endif
    } slot_t;

endpackage

// File: rtl/sort8_cell.sv
// sort8_cell: one storage slot of the insertion sorter.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   op                  : next-value select (hold / load new / take lower / take upper)
//   occupied            : slot currently holds a frame element
//   new_val             : incoming element (also the compare operand)
//   lower_val/upper_val : neighbour slot values for shift-up / shift-down
//   val                 : stored value
//   le                  : occupied & (val <= new_val)
//   new_idx/lower_idx/upper_idx/idx : arrival-index path (SORT8_IDX_EN only)
// Optional feature macro: SORT8_IDX_EN.
module sort8_cell
    import sort8_pkg::*;
#(
    parameter int unsigned W  = SORT8_W
`ifdef SORT8_IDX_EN
   ,parameter int unsigned IW = SORT8_IW
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  slot_op_t      op,
    input  logic          occupied,
    input  logic [W-1:0]  new_val,
    input  logic [W-1:0]  lower_val,
    input  logic [W-1:0]  upper_val,
`ifdef SORT8_IDX_EN
    input  logic [IW-1:0] new_idx,
    input  logic [IW-1:0] lower_idx,
    input  logic [IW-1:0] upper_idx,
    output logic [IW-1:0] idx,
`endif
    output logic [W-1:0]  val,
    output logic          le
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val <= '0;
        end else begin
            case (op)
                OP_NEW:  val <= new_val;
                OP_UP:   val <= lower_val;
                OP_DOWN: val <= upper_val;
                default: val <= val;
            endcase
        end
    end

`ifdef SORT8_IDX_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else begin
            case (op)
                OP_NEW:  idx <= new_idx;
                OP_UP:   idx <= lower_idx;
                OP_DOWN: idx <= upper_idx;
                default: idx <= idx;
            endcase
        end
    end
`endif

    // Empty slots never compare, so no value acts as a sentinel.
    assign le = occupied && (val <= new_val);

endmodule

// File: rtl/sort8_stream.sv
// sort8_stream: streaming N-entry insertion sorter.
// Accepts one unsigned element per cycle (LOAD), keeps the slots ascending,
// then drains the frame smallest-first (DRAIN). Equal values leave in arrival
// order.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready=1 only in LOAD)
//   in_data             : input element
//   out_valid/out_ready : output handshake (out_valid=1 only in DRAIN)
//   out_data            : smallest remaining element (register of slot 0)
//   out_last            : out_data is the final element of the frame
//   out_idx             : arrival index of out_data (SORT8_IDX_EN only)
// Optional feature macro: SORT8_IDX_EN.
module sort8_stream
    import sort8_pkg::*;
#(
    parameter int unsigned W = SORT8_W,
    parameter int unsigned N = SORT8_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
`ifdef SORT8_IDX_EN
    output logic [$clog2(N)-1:0] out_idx,
`endif
    output logic                 out_last
);

    localparam int unsigned CW = $clog2(N + 1);
`ifdef SORT8_IDX_EN
    localparam int unsigned IW = $clog2(N);
`endif

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  k;
    logic [N-1:0]   le;
    logic [W-1:0]   val [N];
`ifdef SORT8_IDX_EN
    logic [IW-1:0]  idx [N];
`endif
    logic           accept;
    logic           drain_hs;
    logic           last;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs depend on state only; in_valid/out_ready only steer
    // the next state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (cnt_q == CW'(N - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && last) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign drain_hs = out_valid & out_ready;
    assign last     = (state_q == DRAIN) && (cnt_q == CW'(1));

    // ---------------- occupancy count ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (drain_hs) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Slots are ascending, so the set compare bits form a prefix and their
    // population count is the insert position.
    always_comb begin
        k = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (le[j]) begin
                k = k + CW'(1);
            end
        end
    end

    // ---------------- slot array ----------------
    for (genvar i = 0; i < N; i++) begin : g_slot
        slot_op_t      op;
        logic          occupied;
        logic [W-1:0]  lower_v, upper_v;

        assign occupied = (CW'(i) < cnt_q);

        always_comb begin
            op = OP_HOLD;
            if (accept) begin
                if (CW'(i) == k) begin
                    op = OP_NEW;
                end else if ((CW'(i) > k) && (CW'(i) <= cnt_q)) begin
                    op = OP_UP;
                end
            end else if (drain_hs) begin
                op = OP_DOWN;
            end
        end

        if (i == 0) begin : g_lo0
            assign lower_v = '0;
        end else begin : g_lo
            assign lower_v = val[i-1];
        end
        if (i == N - 1) begin : g_hiN
            assign upper_v = '0;
        end else begin : g_hi
            assign upper_v = val[i+1];
        end

`ifdef SORT8_IDX_EN
        logic [IW-1:0] lower_i, upper_i;
        if (i == 0) begin : g_loi0
            assign lower_i = '0;
        end else begin : g_loi
            assign lower_i = idx[i-1];
        end
        if (i == N - 1) begin : g_hiiN
            assign upper_i = '0;
        end else begin : g_hii
            assign upper_i = idx[i+1];
        end
`endif

        sort8_cell #(
            .W  (W)
`ifdef SORT8_IDX_EN
           ,.IW (IW)
`endif
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .op        (op),
            .occupied  (occupied),
            .new_val   (in_data),
            .lower_val (lower_v),
            .upper_val (upper_v),
`ifdef SORT8_IDX_EN
            .new_idx   (cnt_q[IW-1:0]),
            .lower_idx (lower_i),
            .upper_idx (upper_i),
            .idx       (idx[i]),
`endif
            .val       (val[i]),
            .le        (le[i])
        );
    end

    // ---------------- output drive ----------------
    assign out_data = val[0];
    assign out_last = last;
`ifdef SORT8_IDX_EN
    assign out_idx  = idx[0];
`endif

endmodule

// File: tb/tb_sort8_stream.sv
// tb_sort8_stream: scoreboard bench for sort8_stream (default W=8, N=8).
// Stimulus pushes hand-computed sorted frames into a queue; a monitor pops
// and compares on every output handshake. Index checks are active when
// SORT8_IDX_EN is defined.
module tb_sort8_stream;
    import sort8_pkg::*;

    typedef struct {
        slot_t s;
        logic  last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
`ifdef SORT8_IDX_EN
    logic [2:0] out_idx;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic rnd_mode = 1'b0;

    logic [7:0] vin  [8];
    logic [7:0] vexp [8];
    logic [2:0] iexp [8];

    sort8_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SORT8_IDX_EN
        .out_idx   (out_idx),
`endif
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Consumer: always ready, or random back-pressure.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic       hold_pend;
        logic [7:0] hold_d;
        logic       hold_l;
        exp_t       e;
`ifdef SORT8_IDX_EN
        logic [2:0] hold_i;
`endif
        hold_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL overlap: in_ready=%b during drain, required 0", in_ready);
                    end
                end
                if (hold_pend && out_valid) begin
                    checks++;
                    if (out_data !== hold_d || out_last !== hold_l
`ifdef SORT8_IDX_EN
                        || out_idx !== hold_i
`endif
                    ) begin
                        errors++;
                        $display("FAIL hold: data=%0d last=%b while stalled, required data=%0d last=%b",
                                 out_data, out_last, hold_d, hold_l);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected: data=%0d with empty scoreboard, required no output", out_data);
                    end else begin
                        e = q.pop_front();
                        if (out_data !== e.s.value || out_last !== e.last) begin
                            errors++;
                            $display("FAIL out: data=%0d last=%b, required data=%0d last=%b",
                                     out_data, out_last, e.s.value, e.last);
                        end
`ifdef SORT8_IDX_EN
                        checks++;
                        if (out_idx !== e.s.idx) begin
                            errors++;
                            $display("FAIL idx: data=%0d idx=%0d, required idx=%0d",
                                     out_data, out_idx, e.s.idx);
                        end
`endif
                    end
                end
                hold_pend = out_valid && !out_ready;
                hold_d    = out_data;
                hold_l    = out_last;
`ifdef SORT8_IDX_EN
                hold_i    = out_idx;
`endif
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the release edge.
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_in_ready",  {7'd0, in_ready},  8'd1);
        chk("rst_out_last",  {7'd0, out_last},  8'd0);
        chk("rst_out_data",  out_data,          8'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int   n;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: data=%0d not accepted, required accept within 100 cycles", d);
        end
    endtask

    task automatic send_frame(input logic gap);
        for (int i = 0; i < 8; i++) begin
            send(vin[i]);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.s.value = vexp[i];
`ifdef SORT8_IDX_EN
            e.s.idx   = iexp[i];
`endif
            e.last    = (i == 7);
            q.push_back(e);
        end
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Mixed order.
        vin  = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        iexp = '{3'd3, 3'd5, 3'd1, 3'd7, 3'd0, 3'd6, 3'd2, 3'd4};
        push_exp();
        send_frame(1'b0);
        wait_drained();

        // All 0xFF: no sentinel, stable ties.
        vin  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vexp = vin;
        iexp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        push_exp();
        send_frame(1'b0);
        wait_drained();

        // Descending, producer gaps, random consumer stalls.
        rnd_mode = 1'b1;
        vin  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        iexp = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        push_exp();
        send_frame(1'b1);
        wait_drained();
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;

        // Reset after four accepts; the partial frame must vanish.
        for (int i = 0; i < 4; i++) send(8'd1);
        do_reset();
        vin  = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
        vexp = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        iexp = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        push_exp();
        send_frame(1'b0);
        wait_drained();

        // Reset on the third drain cycle.
        vin  = '{8'd10, 8'd30, 8'd20, 8'd40, 8'd60, 8'd50, 8'd80, 8'd70};
        vexp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        iexp = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd5, 3'd4, 3'd7, 3'd6};
        push_exp();
        send_frame(1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_start", {7'd0, out_valid}, 8'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();
        vin  = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        iexp = '{3'd3, 3'd5, 3'd1, 3'd7, 3'd0, 3'd6, 3'd2, 3'd4};
        push_exp();
        send_frame(1'b0);
        wait_drained();

        // Back-to-back frames.
        vin  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
        vexp = vin;
        iexp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        push_exp();
        send_frame(1'b0);
        vin  = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd150, 8'd175, 8'd75, 8'd125};
        vexp = '{8'd25, 8'd50, 8'd75, 8'd100, 8'd125, 8'd150, 8'd175, 8'd200};
        iexp = '{3'd3, 3'd2, 3'd6, 3'd1, 3'd7, 3'd4, 3'd5, 3'd0};
        push_exp();
        send_frame(1'b0);
        wait_drained();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
